// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bundle for seq_divider
interface seq_divider_if #(parameter int W = 8);
    logic         start;
    logic         op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    modport master (output start, op, x, y, input busy, done, q, r, dbz);
    modport slave  (input start, op, x, y, output busy, done, q, r, dbz);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one trial subtract per clock; SEQ_DIVIDER_SIGNED_EN adds signed divide on op=1
module seq_divider #(parameter int W = 8) (
    input logic clk,
    input logic rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(W);
    localparam logic [1:0] IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W:0]    rem;
    logic [W-1:0]  qsh, yr, q, r;
    logic          dbz;
    logic [W:0]    sh, trial;
    logic [W-1:0]  qn, rn, xm, ym, qf, rf;
    // one shift-and-trial-subtract step; the W+1 bit trial keeps the borrow in its MSB
    always_comb begin
        sh    = {rem[W-1:0], qsh[W-1]};
        trial = sh - {1'b0, yr};
        qn    = {qsh[W-2:0], ~trial[W]};
        rn    = trial[W] ? sh[W-1:0] : trial[W-1:0];
    end
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic nq, nr;
    logic unused_rem;
    assign unused_rem = rem[W];
    assign xm = (bus.op && bus.x[W-1]) ? -bus.x : bus.x;
    assign ym = (bus.op && bus.y[W-1]) ? -bus.y : bus.y;
    assign qf = nq ? -qn : qn;
    assign rf = nr ? -rn : rn;
    // remember result signs at capture so the fix-up lands on the edge entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nq <= 1'b0;
            nr <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            nq <= bus.op & (bus.x[W-1] ^ bus.y[W-1]);
            nr <= bus.op & bus.x[W-1];
        end
    end
`else
    logic unused_in;
    assign unused_in = bus.op ^ rem[W];
    assign xm = bus.x;
    assign ym = bus.y;
    assign qf = qn;
    assign rf = rn;
`endif
    // control FSM, datapath registers and held results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            qsh   <= '0;
            yr    <= '0;
            q     <= '0;
            r     <= '0;
            dbz   <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            yr  <= ym;
            rem <= '0;
            qsh <= xm;
            cnt <= '0;
            if (bus.y == '0) begin
                state <= DONE;
                q     <= '1;
                r     <= bus.x;
                dbz   <= 1'b1;
            end else begin
                state <= DIV;
            end
        end else if (state == DIV) begin
            rem <= trial[W] ? sh : trial;
            qsh <= qn;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(W - 1)) begin
                state <= DONE;
                q     <= qf;
                r     <= rf;
                dbz   <= 1'b0;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign bus.q    = q;
    assign bus.r    = r;
    assign bus.dbz  = dbz;
endmodule
